mlaccel_qpi_host: RTL and testbench

//  Synthesizable QPI bus master driving the mlaccel_top QPI slave port (csb/clk/io/rdy/err).

---
 rtl/mlaccel_qpi_pkg.sv | 35 +++
 rtl/mlaccel_qpi_phase_timer.sv | 37 +++
 rtl/mlaccel_qpi_host.sv | 231 +++++++++++++++++++++++
 tb/tb_mlaccel_qpi_host.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mlaccel_qpi_pkg.sv
// Shared op/state encodings and lane-group helper for the QPI host master.
// Pure definitions; no logic or timing of its own.
// Backpressure: n/a.
package mlaccel_qpi_pkg;

    typedef enum logic [2:0] {
        QOP_START = 3'd0,
        QOP_SEND  = 3'd1,
        QOP_WAIT  = 3'd2,
        QOP_RECV  = 3'd3,
        QOP_STOP  = 3'd4,
        QOP_POLL  = 3'd5
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_SHIFT,
        ST_WAIT_LO,
        ST_WAIT_HI,
        ST_STOP_LO,
        ST_STOP_HI,
        ST_RESP
    } state_e;

    // Lane group k of a byte, MSB group first, right-aligned in 4 bits.
    function automatic logic [3:0] lane_group(input logic [7:0] b,
                                              input int unsigned k,
                                              input int unsigned lanes);
        logic [7:0] sh;
        sh = b >> (8 - (k + 1) * lanes);
        return sh[3:0] & 4'((1 << lanes) - 1);
    endfunction

endpackage

// File: rtl/mlaccel_qpi_phase_timer.sv
// Half-phase timer: counts CLKDIV clocks per phase while run is high.
// Latency: phase_end/last_clk are combinational from the count register.
// Backpressure: none; reloads whenever run is low.
module mlaccel_qpi_phase_timer #(
    parameter int CLKDIV = 2
) (
    input  logic clock,
    input  logic resetn,
    input  logic run,
    output logic phase_end,
    output logic last_clk
);

    localparam int CW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLKDIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = RELOAD;
        if (run && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_clk  = (cnt_q == '0);
    assign phase_end = run && last_clk;

endmodule

// File: rtl/mlaccel_qpi_host.sv
// QPI bus master executing START/SEND/WAIT/RECV/STOP/POLL byte ops on the pads.
// Latency: op starts the cycle after acceptance; each phase lasts CLKDIV clocks.
// Backpressure: cmd_ready only in IDLE; rsp is a pulse with no backpressure.
module mlaccel_qpi_host #(
    parameter int LANES    = 4,
    parameter int CLKDIV   = 2,
    parameter int POLL_MAX = 256
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [7:0]       cmd_data,
    output logic             rsp_valid,
    output logic [7:0]       rsp_data,
    output logic             rsp_last,
    output logic             busy,
    output logic             proto_err,
    output logic             poll_tmo,
    output logic             qpi_csb,
    output logic             qpi_clk,
    output logic [LANES-1:0] qpi_io_o,
    output logic             qpi_io_oe,
    input  logic [LANES-1:0] qpi_io_i
);
    import mlaccel_qpi_pkg::*;

    localparam int BCW = $clog2(POLL_MAX + 1);
    localparam logic [BCW-1:0] PMAX    = BCW'(POLL_MAX);
    localparam logic [2:0]     LAST_PH = 3'(8 / LANES - 1);

    state_e           state_q, state_d;
    logic [2:0]       phase_q, phase_d;
    logic [7:0]       shift_q, shift_d;
    logic [BCW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [7:0]       target_q, target_d;
    logic             rx_q, rx_d, poll_q, poll_d;
    logic             csb_q, csb_d, clk_q, clk_d, oe_q, oe_d;
    logic [LANES-1:0] io_q, io_d;
    logic             rsp_valid_q, rsp_valid_d, rsp_last_q, rsp_last_d;
    logic [7:0]       rsp_data_q, rsp_data_d;
    logic             proto_err_q, proto_err_d, poll_tmo_q, poll_tmo_d;

    logic             timer_run, phase_end, last_clk;
    logic [3:0]       grp_next, grp_first;
    logic [7:0]       rx_byte;
    logic [BCW-1:0]   cnt_next;
    logic             match, done;

    assign timer_run = (state_q != ST_IDLE) && (state_q != ST_RESP);

    mlaccel_qpi_phase_timer #(.CLKDIV(CLKDIV)) u_timer (
        .clock     (clock),
        .resetn    (resetn),
        .run       (timer_run),
        .phase_end (phase_end),
        .last_clk  (last_clk)
    );

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        shift_d     = shift_q;
        byte_cnt_d  = byte_cnt_q;
        target_d    = target_q;
        rx_d        = rx_q;
        poll_d      = poll_q;
        csb_d       = csb_q;
        clk_d       = clk_q;
        oe_d        = oe_q;
        io_d        = io_q;
        rsp_valid_d = 1'b0;
        rsp_last_d  = 1'b0;
        rsp_data_d  = rsp_data_q;
        proto_err_d = proto_err_q;
        poll_tmo_d  = poll_tmo_q;

        grp_next  = lane_group(shift_q, 32'(phase_q + 3'd1), LANES);
        grp_first = lane_group(cmd_data, 0, LANES);
        rx_byte   = {shift_q[7-LANES:0], qpi_io_i};
        cnt_next  = (byte_cnt_q >= PMAX) ? byte_cnt_q : byte_cnt_q + 1'b1;
        match     = (rx_byte == target_q);
        done      = !poll_q || match || (cnt_next >= PMAX);

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (op_e'(cmd_op))
                        QOP_START: begin
                            state_d     = ST_START;
                            csb_d       = 1'b0;
                            clk_d       = 1'b1;
                            proto_err_d = 1'b0;
                            poll_tmo_d  = 1'b0;
                        end
                        QOP_STOP: begin
                            state_d = ST_STOP_LO;
                            oe_d    = 1'b0;
                            clk_d   = 1'b0;
                        end
                        QOP_SEND, QOP_WAIT, QOP_RECV, QOP_POLL: begin
                            // Bus not selected: flag it and stay idle, pins untouched.
                            if (csb_q) begin
                                proto_err_d = 1'b1;
                            end else if (op_e'(cmd_op) == QOP_WAIT) begin
                                state_d = ST_WAIT_LO;
                                oe_d    = 1'b0;
                                clk_d   = 1'b0;
                            end else begin
                                state_d    = ST_SHIFT;
                                phase_d    = 3'd0;
                                clk_d      = 1'b0;
                                byte_cnt_d = '0;
                                target_d   = cmd_data;
                                shift_d    = cmd_data;
                                rx_d       = (op_e'(cmd_op) != QOP_SEND);
                                poll_d     = (op_e'(cmd_op) == QOP_POLL);
                                oe_d       = (op_e'(cmd_op) == QOP_SEND);
                                if (op_e'(cmd_op) == QOP_SEND) begin
                                    io_d = grp_first[LANES-1:0];
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_START: begin
                if (phase_end) state_d = ST_IDLE;
            end
            ST_SHIFT: begin
                if (rx_q && last_clk) shift_d = rx_byte;
                if (phase_end) begin
                    if (phase_q == LAST_PH) begin
                        if (rx_q) begin
                            state_d     = ST_RESP;
                            rsp_valid_d = 1'b1;
                            rsp_data_d  = rx_byte;
                            rsp_last_d  = done;
                            byte_cnt_d  = cnt_next;
                            if (poll_q && !match && cnt_next >= PMAX) poll_tmo_d = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        phase_d = phase_q + 3'd1;
                        clk_d   = !clk_q;
                        if (!rx_q) io_d = grp_next[LANES-1:0];
                    end
                end
            end
            ST_RESP: begin
                // rsp_last_q is still the flag of the byte just emitted.
                if (rsp_last_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SHIFT;
                    phase_d = 3'd0;
                    clk_d   = 1'b0;
                end
            end
            ST_WAIT_LO, ST_STOP_LO: begin
                if (phase_end) begin
                    state_d = (state_q == ST_WAIT_LO) ? ST_WAIT_HI : ST_STOP_HI;
                    phase_d = 3'd0;
                    clk_d   = 1'b1;
                    if (state_q == ST_STOP_LO) csb_d = 1'b1;
                end
            end
            ST_WAIT_HI, ST_STOP_HI: begin
                if (phase_end) begin
                    if (phase_q == 3'd1) state_d = ST_IDLE;
                    else                 phase_d = phase_q + 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            phase_q     <= 3'd0;
            shift_q     <= 8'd0;
            byte_cnt_q  <= '0;
            target_q    <= 8'd0;
            rx_q        <= 1'b0;
            poll_q      <= 1'b0;
            csb_q       <= 1'b1;
            clk_q       <= 1'b1;
            oe_q        <= 1'b0;
            io_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_data_q  <= 8'd0;
            proto_err_q <= 1'b0;
            poll_tmo_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            shift_q     <= shift_d;
            byte_cnt_q  <= byte_cnt_d;
            target_q    <= target_d;
            rx_q        <= rx_d;
            poll_q      <= poll_d;
            csb_q       <= csb_d;
            clk_q       <= clk_d;
            oe_q        <= oe_d;
            io_q        <= io_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_last_q  <= rsp_last_d;
            rsp_data_q  <= rsp_data_d;
            proto_err_q <= proto_err_d;
            poll_tmo_q  <= poll_tmo_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = !cmd_ready;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_last  = rsp_last_q;
    assign proto_err = proto_err_q;
    assign poll_tmo  = poll_tmo_q;
    assign qpi_csb   = csb_q;
    assign qpi_clk   = clk_q;
    assign qpi_io_o  = io_q;
    assign qpi_io_oe = oe_q;

endmodule

// File: tb/tb_mlaccel_qpi_host.sv
// Directed bench: 4-lane/CLKDIV=2/POLL_MAX=4 instance (A) and 1-lane/CLKDIV=1 instance (B).
module tb_mlaccel_qpi_host;

    logic       clock;
    logic       rst_a, rst_b;

    logic       cmd_valid_a, cmd_ready_a, rsp_valid_a, rsp_last_a, busy_a, perr_a, tmo_a;
    logic       csb_a, qclk_a, oe_a;
    logic [2:0] cmd_op_a;
    logic [7:0] cmd_data_a, rsp_data_a;
    logic [3:0] io_o_a, io_i_a;

    logic       cmd_valid_b, cmd_ready_b, rsp_valid_b, rsp_last_b, busy_b, perr_b, tmo_b;
    logic       csb_b, qclk_b, oe_b;
    logic [2:0] cmd_op_b;
    logic [7:0] cmd_data_b, rsp_data_b;
    logic [0:0] io_o_b, io_i_b;

    logic [7:0] slist [0:7];
    logic [2:0] sidx;
    logic [7:0] got [0:7];
    int         checks, errors, rsp_cnt, last_cnt;

    // Slave: high nibble while qpi_clk is low, low nibble while high.
    assign io_i_a = qclk_a ? slist[sidx][3:0] : slist[sidx][7:4];
    assign io_i_b = 1'b0;

    mlaccel_qpi_host #(.LANES(4), .CLKDIV(2), .POLL_MAX(4)) dut_a (
        .clock(clock), .resetn(rst_a),
        .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a), .cmd_op(cmd_op_a), .cmd_data(cmd_data_a),
        .rsp_valid(rsp_valid_a), .rsp_data(rsp_data_a), .rsp_last(rsp_last_a),
        .busy(busy_a), .proto_err(perr_a), .poll_tmo(tmo_a),
        .qpi_csb(csb_a), .qpi_clk(qclk_a), .qpi_io_o(io_o_a), .qpi_io_oe(oe_a), .qpi_io_i(io_i_a)
    );

    mlaccel_qpi_host #(.LANES(1), .CLKDIV(1), .POLL_MAX(256)) dut_b (
        .clock(clock), .resetn(rst_b),
        .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_op(cmd_op_b), .cmd_data(cmd_data_b),
        .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b), .rsp_last(rsp_last_b),
        .busy(busy_b), .proto_err(perr_b), .poll_tmo(tmo_b),
        .qpi_csb(csb_b), .qpi_clk(qclk_b), .qpi_io_o(io_o_b), .qpi_io_oe(oe_b), .qpi_io_i(io_i_b)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        if (rsp_valid_a) begin
            if (rsp_cnt < 8) got[rsp_cnt] = rsp_data_a;
            rsp_cnt++;
            if (rsp_last_a) last_cnt++;
            sidx = sidx + 3'd1;
        end
    endtask

    task automatic clear_rsp();
        rsp_cnt  = 0;
        last_cnt = 0;
        sidx     = 3'd0;
    endtask

    task automatic issue_a(input logic [2:0] op, input logic [7:0] d);
        cmd_valid_a = 1'b1;
        cmd_op_a    = op;
        cmd_data_a  = d;
        step();
        cmd_valid_a = 1'b0;
    endtask

    task automatic issue_b(input logic [2:0] op, input logic [7:0] d);
        cmd_valid_b = 1'b1;
        cmd_op_b    = op;
        cmd_data_b  = d;
        step();
        cmd_valid_b = 1'b0;
    endtask

    task automatic wait_ready(input bit sel_b, input string tag);
        for (int i = 0; i < 400; i++) begin
            if (sel_b ? cmd_ready_b : cmd_ready_a) break;
            step();
        end
        chk(tag, 32'(sel_b ? cmd_ready_b : cmd_ready_a), 1);
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_a = 1'b0; rst_b = 1'b0;
        cmd_valid_a = 1'b0; cmd_op_a = 3'd0; cmd_data_a = 8'd0;
        cmd_valid_b = 1'b0; cmd_op_b = 3'd0; cmd_data_b = 8'd0;
        for (int i = 0; i < 8; i++) begin
            slist[i] = 8'h00;
            got[i]   = 8'h00;
        end
        clear_rsp();

        repeat (3) step();
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (10) step();

        chk("rst_csb",   32'(csb_a), 1);
        chk("rst_clk",   32'(qclk_a), 1);
        chk("rst_oe",    32'(oe_a), 0);
        chk("rst_io",    32'(io_o_a), 0);
        chk("rst_ready", 32'(cmd_ready_a), 1);
        chk("rst_busy",  32'(busy_a), 0);
        chk("rst_perr",  32'(perr_a), 0);
        chk("rst_tmo",   32'(tmo_a), 0);
        chk("rst_rsp",   32'(rsp_valid_a), 0);
        chk("rst_b_csb", 32'(csb_b), 1);

        // START, SEND 0x21, STOP on the 4-lane instance
        issue_a(3'd0, 8'h00);
        chk("start_csb",  32'(csb_a), 0);
        chk("start_clk",  32'(qclk_a), 1);
        chk("start_busy", 32'(busy_a), 1);
        wait_ready(1'b0, "start_done");

        issue_a(3'd1, 8'h21);
        chk("send_p0_clk", 32'(qclk_a), 0);
        chk("send_p0_io",  32'(io_o_a), 32'h2);
        chk("send_p0_oe",  32'(oe_a), 1);
        step();
        chk("send_p0b_clk", 32'(qclk_a), 0);
        chk("send_p0b_io",  32'(io_o_a), 32'h2);
        step();
        chk("send_p1_clk", 32'(qclk_a), 1);
        chk("send_p1_io",  32'(io_o_a), 32'h1);
        step();
        chk("send_p1b_io",  32'(io_o_a), 32'h1);
        chk("send_p1b_rdy", 32'(cmd_ready_a), 0);
        step();
        chk("send_ready", 32'(cmd_ready_a), 1);

        issue_a(3'd4, 8'h00);
        chk("stop_lo_clk", 32'(qclk_a), 0);
        chk("stop_lo_csb", 32'(csb_a), 0);
        chk("stop_lo_oe",  32'(oe_a), 0);
        step();
        step();
        chk("stop_hi_csb", 32'(csb_a), 1);
        chk("stop_hi_clk", 32'(qclk_a), 1);
        wait_ready(1'b0, "stop_done");

        // START, SEND, WAIT, RECV 0xA5
        clear_rsp();
        slist[0] = 8'hA5;
        issue_a(3'd0, 8'h00); wait_ready(1'b0, "r_start");
        issue_a(3'd1, 8'h23); wait_ready(1'b0, "r_send");
        issue_a(3'd2, 8'h00);
        chk("wait_clk", 32'(qclk_a), 0);
        chk("wait_oe",  32'(oe_a), 0);
        wait_ready(1'b0, "r_wait");
        issue_a(3'd3, 8'h00);
        chk("recv_oe", 32'(oe_a), 0);
        wait_ready(1'b0, "r_recv");
        chk("recv_cnt",  32'(rsp_cnt), 1);
        chk("recv_data", 32'(got[0]), 32'hA5);
        chk("recv_last", 32'(last_cnt), 1);
        chk("recv_perr", 32'(perr_a), 0);

        // POLL until 0x00: slave returns 03, 02, 00
        clear_rsp();
        slist[0] = 8'h03; slist[1] = 8'h02; slist[2] = 8'h00;
        issue_a(3'd5, 8'h00);
        wait_ready(1'b0, "poll_done");
        chk("poll_cnt",  32'(rsp_cnt), 3);
        chk("poll_d0",   32'(got[0]), 32'h03);
        chk("poll_d1",   32'(got[1]), 32'h02);
        chk("poll_d2",   32'(got[2]), 32'h00);
        chk("poll_last", 32'(last_cnt), 1);
        chk("poll_tmo",  32'(tmo_a), 0);

        // POLL timeout at POLL_MAX=4 with slave stuck at 0xFF
        clear_rsp();
        for (int i = 0; i < 8; i++) slist[i] = 8'hFF;
        issue_a(3'd5, 8'h00);
        wait_ready(1'b0, "tmo_done");
        chk("tmo_cnt",  32'(rsp_cnt), 4);
        chk("tmo_last", 32'(last_cnt), 1);
        chk("tmo_d3",   32'(got[3]), 32'hFF);
        chk("tmo_flag", 32'(tmo_a), 1);
        issue_a(3'd0, 8'h00);
        chk("tmo_clr", 32'(tmo_a), 0);
        wait_ready(1'b0, "tmo_start");

        // Illegal op: no pin activity, stays ready
        issue_a(3'd7, 8'h00);
        chk("ill_ready", 32'(cmd_ready_a), 1);
        chk("ill_csb",   32'(csb_a), 0);
        chk("ill_perr",  32'(perr_a), 0);

        // 1-lane instance: START, SEND 0x80 over 8 single-clock phases
        issue_b(3'd0, 8'h00); wait_ready(1'b1, "b_start");
        issue_b(3'd1, 8'h80);
        chk("b_p0_io",  32'(io_o_b), 1);
        chk("b_p0_clk", 32'(qclk_b), 0);
        chk("b_p0_oe",  32'(oe_b), 1);
        for (int k = 1; k < 8; k++) begin
            step();
            chk("b_pk_io",  32'(io_o_b), 0);
            chk("b_pk_clk", 32'(qclk_b), 32'(k % 2));
        end
        step();
        chk("b_send_ready", 32'(cmd_ready_b), 1);
        issue_b(3'd4, 8'h00); wait_ready(1'b1, "b_stop");

        // SEND without START
        issue_b(3'd1, 8'h55);
        chk("b_perr",  32'(perr_b), 1);
        chk("b_pe_csb", 32'(csb_b), 1);
        chk("b_pe_clk", 32'(qclk_b), 1);
        chk("b_pe_oe",  32'(oe_b), 0);
        chk("b_pe_rdy", 32'(cmd_ready_b), 1);
        issue_b(3'd0, 8'h00);
        chk("b_perr_clr", 32'(perr_b), 0);
        wait_ready(1'b1, "b_start2");

        // Reset pulse mid-SEND
        issue_b(3'd1, 8'hFF);
        step();
        chk("b_mid_oe",   32'(oe_b), 1);
        chk("b_mid_busy", 32'(busy_b), 1);
        #1 rst_b = 1'b0;
        #1;
        chk("b_ar_csb", 32'(csb_b), 1);
        chk("b_ar_clk", 32'(qclk_b), 1);
        chk("b_ar_oe",  32'(oe_b), 0);
        chk("b_ar_io",  32'(io_o_b), 0);
        step();
        rst_b = 1'b1;
        step();
        chk("b_rel_ready", 32'(cmd_ready_b), 1);
        chk("b_rel_busy",  32'(busy_b), 0);
        chk("b_rel_csb",   32'(csb_b), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
